// File: rtl/pattern_stream_gen_pkg.sv
// rtl/pattern_stream_gen_pkg.sv - shared types for the pattern stream generator
package pattern_gen_pkg;

   typedef enum logic [1:0] {
      MODE_INC  = 2'd0,
      MODE_DEC  = 2'd1,
      MODE_HOLD = 2'd2,
      MODE_WALK = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Channel tag width; a single channel still gets a 1-bit tag.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pattern_stream_gen_if.sv
// rtl/pattern_stream_gen_if.sv - output beat stream of the pattern generator
interface pattern_stream_gen_if #(
   parameter int DATA_W = 8,
   parameter int CH_W   = 1
);
   logic [DATA_W-1:0] out_data;
   logic [CH_W-1:0]   out_ch;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output out_data,
      output out_ch,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_ch,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/pattern_stream_gen_lane.sv
// rtl/pattern_stream_gen_lane.sv - one channel's pattern counter with seed and advance
module pattern_lane
   import pattern_gen_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_en,
   input  logic [DATA_W-1:0] seed_val,
   input  mode_e             seed_mode,
   input  logic              adv_en,
   input  mode_e             mode,
   input  logic [DATA_W-1:0] step,
   output logic [DATA_W-1:0] value
);
   logic [DATA_W-1:0] value_d;
   logic [DATA_W-1:0] value_q;
   logic [DATA_W-1:0] next_val;

   always_comb begin
      next_val = value_q;
      case (mode)
         MODE_INC:  next_val = value_q + step;
         MODE_DEC:  next_val = value_q - step;
         MODE_HOLD: next_val = value_q;
         MODE_WALK: next_val = (value_q << 1) | (value_q >> (DATA_W - 1));
         default:   next_val = value_q;
      endcase
   end

   // A zero seed would walk forever as zero, so WALK starts from 1 instead.
   always_comb begin
      value_d = value_q;
      if (seed_en) begin
         if (seed_mode == MODE_WALK && seed_val == '0) begin
            value_d = DATA_W'(1);
         end else begin
            value_d = seed_val;
         end
      end else if (adv_en) begin
         value_d = next_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
endmodule

// File: rtl/pattern_stream_gen.sv
// rtl/pattern_stream_gen.sv - multi-channel test-data source with burst control
module pattern_stream_gen
   import pattern_gen_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int NUM_CH  = 2,
   parameter int BEATS_W = 8,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic [BEATS_W-1:0]   beats,
   input  logic [DATA_W-1:0]    init_val,
   input  logic [DATA_W-1:0]    step,
   pattern_stream_gen_if.master out_if,
   output logic                 busy,
   output logic                 done
);
   state_e             state_d, state_q;
   mode_e              mode_d, mode_q;
   logic [DATA_W-1:0]  step_d, step_q;
   logic [BEATS_W-1:0] left_d, left_q;
   logic [CH_W-1:0]    ptr_d, ptr_q;
   logic               valid_d, valid_q;
   logic               last_d, last_q;
   logic               busy_d, busy_q;
   logic               done_d, done_q;

   logic               fire;
   logic               seed_en;
   logic [DATA_W-1:0]  lane_val [NUM_CH];
   logic [DATA_W-1:0]  data_mux;

   assign fire    = valid_q && out_if.out_ready;
   assign seed_en = (state_q == S_IDLE) && start;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      pattern_lane #(.DATA_W(DATA_W)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .seed_en   (seed_en),
         .seed_val  (init_val + DATA_W'(c)),
         .seed_mode (mode_e'(mode)),
         .adv_en    (fire && (ptr_q == CH_W'(c))),
         .mode      (mode_q),
         .step      (step_q),
         .value     (lane_val[c])
      );
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      step_d  = step_q;
      left_d  = left_q;
      ptr_d   = ptr_q;
      valid_d = valid_q;
      last_d  = last_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d = mode_e'(mode);
               step_d = step;
               left_d = beats;
               ptr_d  = '0;
               if (beats == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  last_d  = (beats == BEATS_W'(1));
               end
            end
         end
         S_RUN: begin
            if (fire) begin
               if (left_q == BEATS_W'(1)) begin
                  state_d = S_DONE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  left_d = left_q - BEATS_W'(1);
                  last_d = (left_q == BEATS_W'(2));
                  ptr_d  = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + CH_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_INC;
         step_q  <= '0;
         left_q  <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         step_q  <= step_d;
         left_q  <= left_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // The untransferred channels never advance, so the pointer alone selects the beat.
   always_comb begin
      data_mux = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ptr_q == CH_W'(c)) begin
            data_mux = lane_val[c];
         end
      end
   end

   assign out_if.out_data  = data_mux;
   assign out_if.out_ch    = ptr_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_last  = last_q;
   assign busy             = busy_q;
   assign done             = done_q;
endmodule

// File: tb/tb_pattern_stream_gen.sv
// tb/tb_pattern_stream_gen.sv - bench for pattern_stream_gen with two- and one-channel instances
module tb_pattern_stream_gen;
   import pattern_gen_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cfg_mode = 2'd0;
   logic [7:0] cfg_beats = 8'd0;
   logic [7:0] cfg_init = 8'd0;
   logic [7:0] cfg_step = 8'd0;
   logic       rdy = 1'b1;
   int         sel = 0;
   int         checks = 0;
   int         errors = 0;

   logic       start2, start1;
   logic       busy2, done2, busy1, done1;
   logic [7:0] o_data;
   logic       o_ch, o_valid, o_last, o_busy, o_done;

   pattern_stream_gen_if #(.DATA_W(8), .CH_W(1)) if2 ();
   pattern_stream_gen_if #(.DATA_W(8), .CH_W(1)) if1 ();

   assign start2        = start && (sel == 0);
   assign start1        = start && (sel == 1);
   assign if2.out_ready = rdy;
   assign if1.out_ready = rdy;

   pattern_stream_gen #(.DATA_W(8), .NUM_CH(2), .BEATS_W(8)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .mode(cfg_mode), .beats(cfg_beats),
      .init_val(cfg_init), .step(cfg_step), .out_if(if2), .busy(busy2), .done(done2)
   );

   pattern_stream_gen #(.DATA_W(8), .NUM_CH(1), .BEATS_W(8)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .mode(cfg_mode), .beats(cfg_beats),
      .init_val(cfg_init), .step(cfg_step), .out_if(if1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (sel == 0) begin
         o_data = if2.out_data; o_ch = if2.out_ch; o_valid = if2.out_valid;
         o_last = if2.out_last; o_busy = busy2;    o_done = done2;
      end else begin
         o_data = if1.out_data; o_ch = if1.out_ch; o_valid = if1.out_valid;
         o_last = if1.out_last; o_busy = busy1;    o_done = done1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " data"}, 32'(o_data), 32'd0);
      check({tag, " ch"}, 32'(o_ch), 32'd0);
      check({tag, " valid"}, 32'(o_valid), 32'd0);
      check({tag, " last"}, 32'(o_last), 32'd0);
      check({tag, " busy"}, 32'(o_busy), 32'd0);
      check({tag, " done"}, 32'(o_done), 32'd0);
   endtask

   // Called at a falling edge; returns at a falling edge with the DUT idle.
   task automatic run_burst(input int d, input logic [1:0] m, input logic [7:0] iv,
                            input logic [7:0] st, input int nb, input int stall_idx,
                            input int stall_n, input bit rnd_bp, input int restart_idx,
                            input int abort_idx);
      logic [7:0] v [2];
      logic [7:0] exp_d [$];
      int         exp_c [$];
      int         nch, idx, stalls, cyc, c;
      bit         restarted;

      nch = (d == 1) ? 1 : 2;
      for (int k = 0; k < nch; k++) begin
         v[k] = iv + 8'(k);
         if (m == MODE_WALK && v[k] == 8'd0) v[k] = 8'd1;
      end
      for (int i = 0; i < nb; i++) begin
         c = i % nch;
         exp_d.push_back(v[c]);
         exp_c.push_back(c);
         case (m)
            MODE_INC:  v[c] = v[c] + st;
            MODE_DEC:  v[c] = v[c] - st;
            MODE_WALK: v[c] = {v[c][6:0], v[c][7]};
            default:   v[c] = v[c];
         endcase
      end

      sel = d; cfg_mode = m; cfg_init = iv; cfg_step = st; cfg_beats = 8'(nb);
      rdy = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idx = 0; stalls = stall_n; cyc = 0; restarted = 1'b0;

      while (idx < nb && cyc < 2000) begin
         if (idx == abort_idx) begin
            rst = 1'b1;
            #1;
            check_quiet("abort");
            @(negedge clk);
            rst = 1'b0;
            check("abort done0", 32'(o_done), 32'd0);
            @(negedge clk);
            check("abort done1", 32'(o_done), 32'd0);
            check("abort valid", 32'(o_valid), 32'd0);
            return;
         end
         check($sformatf("beat%0d valid", idx), 32'(o_valid), 32'd1);
         check($sformatf("beat%0d busy", idx), 32'(o_busy), 32'd1);
         check($sformatf("beat%0d done", idx), 32'(o_done), 32'd0);
         check($sformatf("beat%0d ch", idx), 32'(o_ch), 32'(exp_c[idx]));
         check($sformatf("beat%0d data", idx), 32'(o_data), 32'(exp_d[idx]));
         check($sformatf("beat%0d last", idx), 32'(o_last), 32'(idx == nb - 1));

         if (idx == stall_idx && stalls > 0) begin
            rdy = 1'b0;
            stalls--;
         end else if (rnd_bp) begin
            rdy = ($urandom_range(0, 3) != 0);
         end else begin
            rdy = 1'b1;
         end
         if (idx == restart_idx && !restarted) begin
            start = 1'b1;
            cfg_beats = 8'(nb + 3);
            restarted = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (rdy) idx++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      rdy = 1'b1;
      check("burst completed in budget", 32'(cyc < 2000), 32'd1);
      check("end done", 32'(o_done), 32'd1);
      check("end valid", 32'(o_valid), 32'd0);
      check("end busy", 32'(o_busy), 32'd0);
      check("end last", 32'(o_last), 32'd0);
      @(negedge clk);
      check("post done", 32'(o_done), 32'd0);
      check("post valid", 32'(o_valid), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      sel = 0; #1; check_quiet("reset dut2");
      sel = 1; #1; check_quiet("reset dut1");
      rst = 1'b0;
      @(negedge clk);

      run_burst(0, MODE_INC, 8'h00, 8'h01, 6, -1, 0, 1'b0, -1, -1);
      run_burst(0, MODE_INC, 8'h00, 8'h01, 6, 1, 3, 1'b0, -1, -1);
      run_burst(1, MODE_DEC, 8'h01, 8'h02, 3, -1, 0, 1'b0, -1, -1);
      run_burst(1, MODE_WALK, 8'h00, 8'h00, 9, -1, 0, 1'b0, -1, -1);
      run_burst(0, MODE_INC, 8'h10, 8'h01, 0, -1, 0, 1'b0, -1, -1);
      run_burst(0, MODE_INC, 8'h20, 8'h03, 4, -1, 0, 1'b0, 1, -1);
      run_burst(0, MODE_INC, 8'h00, 8'h01, 5, -1, 0, 1'b0, -1, 2);
      run_burst(0, MODE_HOLD, 8'h5A, 8'h07, 2, -1, 0, 1'b0, -1, -1);
      run_burst(0, MODE_WALK, 8'hFF, 8'h00, 7, -1, 0, 1'b0, -1, -1);
      run_burst(0, MODE_DEC, 8'h03, 8'h80, 5, -1, 0, 1'b0, -1, -1);

      for (int r = 0; r < 20; r++) begin
         run_burst($urandom_range(0, 1), 2'($urandom_range(0, 3)), 8'($urandom),
                   8'($urandom), $urandom_range(0, 12), -1, 0, 1'b1, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pattern_stream_gen.md
Name: pattern_stream_gen

Overview:
- Parametrised multi-channel test-data source with a valid/ready handshake and an optional per-beat channel tag.
- Produces a programmed number of beats drawn from per-channel pattern counters.
- Sits in front of DUT input interfaces in benches and in synthesizable self-test paths.
- Successor to the fixed 8-bit data/valid incrementer. Adds configurable width and channels, backpressure, pattern modes, burst length, and last/done signalling.

Parameters:
- DATA_W, 8, width of each data beat.
- NUM_CH, 2, number of independent pattern channels; must be at least 1.
- BEATS_W, 8, width of the burst-length field (maximum burst = 2^BEATS_W-1).
- CH_W, $clog2(NUM_CH) with a minimum of 1, width of the channel tag (derived; do not override).

Ports:
- clk  in  1  Single clock; all logic on its rising edge.
- rst  in  1  Asynchronous, active-high reset.
- start  in  1  Single-cycle pulse that launches a burst; honoured only in IDLE.
- mode  in  2  Pattern mode: 0 INC, 1 DEC, 2 HOLD, 3 WALK.
- beats  in  BEATS_W  Total beats in the burst, summed across all channels.
- init_val  in  DATA_W  Seed value; channel c seeds with init_val+c, modulo 2^DATA_W.
- step  in  DATA_W  Increment or decrement amount for INC and DEC.
- out_data  out  DATA_W  Current beat.
- out_ch  out  CH_W  Channel that produced out_data.
- out_valid  out  1  Beat available.
- out_ready  in  1  Sink accepts the beat.
- out_last  out  1  Qualifies the final beat of the burst.
- busy  out  1  High in RUN.
- done  out  1  One-cycle pulse after the final transfer.

Behaviour:
- Reset (async assert, sync release): state IDLE. out_data, out_ch, out_valid, out_last, busy and done are all 0. All channel counters are 0. Asserting reset mid-burst aborts immediately, with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE with start: latch mode, beats and step, and seed every channel counter. If beats==0 go to DONE, otherwise go to RUN.
  - RUN, when the transfer with the remaining count at 1 completes: go to DONE.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- start is ignored in RUN and DONE. Config inputs are sampled only on the accepted start.
- Latency: start accepted at edge t gives out_valid=1, out_ch=0 and out_data=seed0 after edge t.
- Transfer happens when out_valid && out_ready at a rising edge.
- While out_valid && !out_ready, out_data, out_ch and out_last hold stable.
- out_valid stays high continuously through RUN. There are no bubbles: the next beat is presented in the cycle after a transfer.
- Channel order is round-robin 0,1,...,NUM_CH-1,0,...
- A channel's counter advances only when that channel's own beat transfers. Its next value:
  - INC: v+step, modulo 2^DATA_W, with wrap-around.
  - DEC: v-step, modulo 2^DATA_W, with wrap-around.
  - HOLD: v unchanged.
  - WALK: rotate v left by 1. A seed of 0 is replaced with 1 at seed time.
- out_last is high together with out_valid only on the beat where the remaining count is 1.
- After the DONE cycle, out_valid drops to 0. Counters retain their values until the next start reseeds them.
- NUM_CH==1: out_ch is constantly 0.
- beats==0: no valid is ever asserted; done pulses one cycle after start.

Decomposition:
- Package pattern_gen_pkg:
  - mode_e enum (MODE_INC=0, MODE_DEC=1, MODE_HOLD=2, MODE_WALK=3).
  - state_e enum (S_IDLE, S_RUN, S_DONE).
- Sub-module pattern_lane, instantiated NUM_CH times. It holds one DATA_W counter plus seed, advance and next-value logic for the mode.
- The top level owns the FSM, the beat counter, the round-robin pointer and the output mux.

Test Plan:
- Basic INC, DATA_W=8, NUM_CH=2, init_val=0, step=1, beats=6, out_ready=1 → (ch,data) sequence (0,0)(1,1)(0,1)(1,2)(0,2)(1,3). out_last on the 6th beat only; done pulses the cycle after it.
- Backpressure: the same run with out_ready low for 3 cycles on beat 2 → beat 2 holds (1,1) stable for all 3 cycles. The sequence is unchanged and no beats are lost or duplicated.
- Wrap, mode DEC, NUM_CH=1, init_val=8'h01, step=2, beats=3 → 01, FF, FD.
- WALK, NUM_CH=1, init_val=0, beats=9 → 01, 02, 04, ..., 80, 01.
- beats=0 → out_valid never rises, busy never rises, and done pulses one cycle after start. A start issued during RUN of a beats=4 burst is ignored: exactly 4 beats transfer.
- Reset mid-burst: assert rst after 2 of 5 transfers → all outputs 0 immediately and no done pulse. A new start with HOLD, init_val=8'h5A, beats=2 yields 5A, 5B on ch0 and ch1.
